// File: rtl/hazard_ctrl_unit_if.sv
// ID-stage hazard request bundle and the hazard unit's control responses.
// The master modport is the pipeline side; the slave modport is the hazard unit.
interface hazard_ctrl_unit_if #(
   parameter int unsigned REG_AW = 5,
   parameter int unsigned CNT_W  = 32
);
   logic              id_valid;
   logic [REG_AW-1:0] id_rs1;
   logic [REG_AW-1:0] id_rs2;
   logic              id_use_rs1;
   logic              id_use_rs2;
   logic [REG_AW-1:0] id_rd;
   logic              id_regwrite;
   logic              id_memread;
   logic              id_is_branch;
   logic              branch_taken;
   logic              stall;
   logic              flush_ifid;
   logic [2:0]        fwd_a_sel;
   logic [2:0]        fwd_b_sel;
   logic [CNT_W-1:0]  stall_cnt;

   modport master (
      output id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd,
             id_regwrite, id_memread, id_is_branch, branch_taken,
      input  stall, flush_ifid, fwd_a_sel, fwd_b_sel, stall_cnt
   );

   modport slave (
      input  id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd,
             id_regwrite, id_memread, id_is_branch, branch_taken,
      output stall, flush_ifid, fwd_a_sel, fwd_b_sel, stall_cnt
   );
endinterface

// File: rtl/hazard_ctrl_unit.sv
// Hazard control: shadow pipeline of in-flight destinations, forwarding selects,
// load-use stall and IF/ID flush. Define HAZARD_BRANCH_OPERAND_EN to also stall ID branches on operand hazards.
module hazard_ctrl_unit #(
   parameter int unsigned REG_AW     = 5,
   parameter int unsigned FWD_STAGES = 2,
   parameter int unsigned LOAD_AVAIL = 2,
   parameter int unsigned CNT_W      = 32
) (
   input logic              clk,
   input logic              rst,
   hazard_ctrl_unit_if.slave hz
);

   typedef struct packed {
      logic              valid;
      logic [REG_AW-1:0] rd;
      logic              regwrite;
      logic              memread;
      logic [REG_AW-1:0] rs1;
      logic [REG_AW-1:0] rs2;
      logic              use_rs1;
      logic              use_rs2;
   } entry_t;

   entry_t           ent_q [0:FWD_STAGES];
   entry_t           ent_d [0:FWD_STAGES];
   logic [CNT_W-1:0] stall_cnt_q;
   logic [CNT_W-1:0] stall_cnt_d;
   logic             stall;
   logic             load_hit;
   logic             branch_hit;
   logic [2:0]       fwd_a;
   logic [2:0]       fwd_b;

   function automatic logic producer(input entry_t e);
      return e.valid & e.regwrite & (e.rd != '0);
   endfunction

   // Scan oldest to youngest so the youngest matching producer overwrites.
   always_comb begin
      fwd_a = '0;
      fwd_b = '0;
      if (ent_q[0].valid) begin
         for (int unsigned k = FWD_STAGES; k >= 1; k--) begin
            if (producer(ent_q[k]) && ent_q[0].use_rs1 && (ent_q[k].rd == ent_q[0].rs1))
               fwd_a = 3'(k);
            if (producer(ent_q[k]) && ent_q[0].use_rs2 && (ent_q[k].rd == ent_q[0].rs2))
               fwd_b = 3'(k);
         end
      end
   end

   always_comb begin
      load_hit = 1'b0;
      for (int unsigned j = 0; j < FWD_STAGES; j++) begin
         if (((j + 1) < LOAD_AVAIL) && producer(ent_q[j]) && ent_q[j].memread &&
             ((hz.id_use_rs1 && (ent_q[j].rd == hz.id_rs1)) ||
              (hz.id_use_rs2 && (ent_q[j].rd == hz.id_rs2))))
            load_hit = 1'b1;
      end
   end

`ifdef HAZARD_BRANCH_OPERAND_EN
   // ID comparator reads the register file, so any not-yet-written operand must wait.
   always_comb begin
      branch_hit = 1'b0;
      if (hz.id_is_branch && hz.id_valid) begin
         for (int unsigned j = 0; j <= FWD_STAGES; j++) begin
            if (producer(ent_q[j]) && ((j == 0) || (ent_q[j].memread && (j < LOAD_AVAIL))) &&
                ((hz.id_use_rs1 && (ent_q[j].rd == hz.id_rs1)) ||
                 (hz.id_use_rs2 && (ent_q[j].rd == hz.id_rs2))))
               branch_hit = 1'b1;
         end
      end
   end
`else
   assign branch_hit = 1'b0;
`endif

   assign stall = (hz.id_valid & load_hit) | branch_hit;

   always_comb begin
      ent_d[0] = '0;
      if (hz.id_valid && !stall) begin
         ent_d[0].valid    = 1'b1;
         ent_d[0].rd       = hz.id_rd;
         ent_d[0].regwrite = hz.id_regwrite;
         ent_d[0].memread  = hz.id_memread;
         ent_d[0].rs1      = hz.id_rs1;
         ent_d[0].rs2      = hz.id_rs2;
         ent_d[0].use_rs1  = hz.id_use_rs1;
         ent_d[0].use_rs2  = hz.id_use_rs2;
      end
      for (int unsigned k = 1; k <= FWD_STAGES; k++)
         ent_d[k] = ent_q[k-1];
   end

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (stall && (stall_cnt_q != '1))
         stall_cnt_d = stall_cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int unsigned k = 0; k <= FWD_STAGES; k++)
            ent_q[k] <= '0;
         stall_cnt_q <= '0;
      end else begin
         ent_q       <= ent_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign hz.stall      = stall;
   assign hz.flush_ifid = hz.branch_taken & hz.id_is_branch & hz.id_valid & ~stall;
   assign hz.fwd_a_sel  = fwd_a;
   assign hz.fwd_b_sel  = fwd_b;
   assign hz.stall_cnt  = stall_cnt_q;

endmodule

// File: doc/hazard_ctrl_unit.md
Name: hazard_ctrl_unit

Overview:
- Parametrised successor to the split forward/hazard logic of the 5-stage RISC-V core: one block owning in-flight destination tracking, operand forwarding selects, load-use stalls and IF/ID flush.
- Keeps its own shadow pipeline of FWD_STAGES+1 entries (EX, MEM, WB, …), so deeper pipelines and multi-cycle load latency need no rework in the top level.
- Sits beside the pipeline registers; drives PC hold, IF/ID hold/flush, ID/EX bubble and the EX forwarding muxes.

Parameters:
- REG_AW, 5, register address width.
- FWD_STAGES, 2, number of post-EX stages that can forward (1 = MEM, 2 = WB, …); range 1..6.
- LOAD_AVAIL, 2, first shadow stage index (EX = 0) from which load data is forwardable; range 1..FWD_STAGES.
- CNT_W, 32, stall counter width.

Ports:
- clk  in  1  core clock.
- rst  in  1  synchronous reset, active-low.
- id_valid  in  1  ID holds a real instruction.
- id_rs1, id_rs2  in  REG_AW  ID source registers.
- id_use_rs1, id_use_rs2  in  1  ID instruction reads rs1/rs2.
- id_rd  in  REG_AW  ID destination.
- id_regwrite  in  1  ID instruction writes rd.
- id_memread  in  1  ID instruction is a load.
- id_is_branch  in  1  ID instruction is a conditional branch (compared in ID).
- branch_taken  in  1  ID comparator result AND branch.
- stall  out  1  hold PC and IF/ID; bubble into ID/EX.
- flush_ifid  out  1  zero IF/ID on next edge.
- fwd_a_sel, fwd_b_sel  out  3  EX operand select: 0 = ID/EX register data, k = shadow stage k (1..FWD_STAGES).
- stall_cnt  out  CNT_W  cycles with stall = 1, saturating.

Behaviour:
- Shadow entry fields: valid, rd, regwrite, memread, rs1, rs2, use_rs1, use_rs2.
- Every clock edge: entry[k] <= entry[k-1] for k = 1..FWD_STAGES; the oldest entry falls off.
- entry[0] (EX) <= ID fields when id_valid & !stall; otherwise entry[0] <= bubble (valid = 0).
- Producer(k) is true when entry[k].valid & regwrite & rd != 0.
- Forwarding (combinational from registers):
  - fwd_a_sel = smallest k in 1..FWD_STAGES with producer(k) & entry[k].rd == entry[0].rs1 & entry[0].use_rs1, else 0.
  - Youngest producer wins. x0 is never forwarded. fwd_b_sel is the same with rs2.
  - Both selects are 0 when entry[0] is invalid.
- Load-use stall: stall = 1 if, for some j in 0..FWD_STAGES-1, entry[j] is a producer with memread, matches an ID source with its use bit set, id_valid = 1, and j+1 < LOAD_AVAIL.
  - Default parameters reproduce the classic 1-cycle load-use bubble.
- A stall lasts exactly until the load advances far enough. No other stall sources exist (except under the optional feature).
- Flush:
  - flush_ifid = branch_taken & id_is_branch & id_valid & !stall.
  - Stall has priority: a branch whose operands are stalled is not resolved that cycle.
- Stall and flush are never both 1.
- stall_cnt increments on each edge where stall = 1, and saturates at all ones.
- Reset (rst = 0 at an edge):
  - All entries become invalid; stall_cnt = 0.
  - Hence stall = 0, flush_ifid = 0, fwd_a_sel = fwd_b_sel = 0 from the first post-reset cycle.
  - Reset mid-stall drops the stall immediately.
  - branch_taken during reset still produces flush_ifid combinationally. The top level ORs rst into the pipeline register resets, so this is harmless.
- All compares use the full REG_AW bits.

Optional Feature:
- Macro: HAZARD_BRANCH_OPERAND_EN.
- Defined: when id_is_branch & id_valid, stall also asserts if an ID source register (use bit set, != 0) matches:
  - a producer in entry[0], or
  - a load producer in entry[j] with j < LOAD_AVAIL.
- This covers the case where the ID comparator would read stale register-file data. These cycles count in stall_cnt.
- Not defined: branches use only the load-use rule, matching current core behaviour. The software schedule must then avoid branch-operand hazards.

Test Plan:
- Reset: hold rst = 0 for 2 cycles with random inputs, then release -> stall = 0, flush_ifid = 0, fwd_a_sel = fwd_b_sel = 0, stall_cnt = 0.
- Back-to-back ALU: add x5 then sub x6,x5,x7 -> when sub is in EX, fwd_a_sel = 1. Insert one NOP between them -> fwd_a_sel = 2. Two NOPs -> 0.
- Double producer: add x5; add x5; use x5 -> fwd selects 1 (youngest), never 2.
- Load-use: lw x8 then add x9,x8,x8 -> stall = 1 for exactly 1 cycle, bubble in EX, then fwd_a_sel = fwd_b_sel = 2, stall_cnt = 1. Repeat with LOAD_AVAIL = 3, FWD_STAGES = 3 -> 2 stall cycles, then select 3.
- x0: lw x0 then add x1,x0,x0 -> no stall, selects 0.
- Branch: taken beq with no hazard -> flush_ifid = 1 for 1 cycle. lw x3 then beq x3,x4 -> stall first, flush_ifid only in the cycle after stall drops. With HAZARD_BRANCH_OPERAND_EN, addi x3 then beq x3 -> 1 stall cycle; without it -> 0 stall cycles.
